// File: rtl/rr_mux_stage_if.sv
`default_nettype none
// ============================================================================
// rr_mux_stage_if : handshake bundle between N producers, the selector and
//                   its single consumer.                        Rev 1.0
// ============================================================================
interface rr_mux_stage_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface
`default_nettype wire

// File: rtl/rr_mux_stage.sv
`default_nettype none
// ============================================================================
// rr_mux_stage : N-channel round-robin selector with one registered output
//                stage and valid/ready handshakes.          Rev 1.0
// ============================================================================
module rr_mux_stage #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic          clk,
  input  logic          resetn,
  rr_mux_stage_if.slave bus
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  logic             can_load;
  logic             accept;
  logic             hi_found, lo_found;
  logic [SEL_W-1:0] hi_idx, lo_idx;
  logic             grant_found;
  logic [SEL_W-1:0] grant_idx;

  // Rotated priority as two plain searches: lowest valid index at/after ptr,
  // otherwise lowest valid index below ptr.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        if (SEL_W'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = SEL_W'(i);
        end
      end
    end
    grant_found = hi_found || lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  assign can_load = !out_valid_q || bus.out_ready;
  assign accept   = resetn && can_load && grant_found;

  for (genvar i = 0; i < N; i++) begin : g_ready
    assign bus.in_ready[i] = accept && (grant_idx == SEL_W'(i));
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (can_load) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_sel_d  = grant_idx;
        // Explicit wrap so non-power-of-two N never lands on an unused index.
        ptr_d      = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule
`default_nettype wire
